// File: rtl/seq_chain_top.sv
// seq_chain_top: self-starting three-step register chain.
// Loads INIT_VAL into a, ripples a->b->c once, then idles.
module seq_chain_top #(
  parameter int          WIDTH    = 8,
  parameter int unsigned INIT_VAL = 48
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);

  typedef enum logic [2:0] {
    START = 3'd0,
    WR_A  = 3'd1,
    WR_B  = 3'd2,
    WR_C  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VAL);

  state_t state;
  state_t state_nxt;
  logic   wr_a;
  logic   wr_b;
  logic   wr_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= START;
    else      state <= state_nxt;
  end

  // Stray encodings fall back to START with no write enabled.
  always_comb begin
    state_nxt = START;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    wr_c      = 1'b0;
    case (state)
      START: state_nxt = WR_A;
      WR_A: begin
        state_nxt = WR_B;
        wr_a      = 1'b1;
      end
      WR_B: begin
        state_nxt = WR_C;
        wr_b      = 1'b1;
      end
      WR_C: begin
        state_nxt = DONE;
        wr_c      = 1'b1;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a <= '0;
      b <= '0;
      c <= '0;
    end else begin
      if (wr_a) a <= INIT_W;
      if (wr_b) b <= a;
      if (wr_c) c <= b;
    end
  end

endmodule

// File: tb/tb_seq_chain_top.sv
// tb_seq_chain_top: vector table, corner sequences and random resets
// for three parameterisations of seq_chain_top.
module tb_seq_chain_top;

  logic       clk;
  logic       rst;
  logic [7:0] a8, b8, c8;
  logic [3:0] a4, b4, c4;
  logic [7:0] af, bf, cf;

  int checks = 0;
  int errors = 0;
  int n      = 0;

  seq_chain_top #(.WIDTH(8), .INIT_VAL(48)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8)
  );
  seq_chain_top #(.WIDTH(4), .INIT_VAL(48)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4)
  );
  seq_chain_top #(.WIDTH(8), .INIT_VAL(255)) dutf (
    .clk(clk), .rst(rst), .a(af), .b(bf), .c(cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: number of qualifying edges since the last reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst)          n = 0;
    else if (n < 1000) n = n + 1;
  end

  typedef struct {
    int         edges;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[4];

  function automatic int unsigned ref_val(int edges, int idx,
                                          int unsigned init, int w);
    int unsigned m;
    m = (32'd1 << w) - 1;
    return (edges >= idx + 2) ? (init & m) : 0;
  endfunction

  task automatic check(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, " a8"}, a8, ref_val(n, 0, 48, 8));
    check({tag, " b8"}, b8, ref_val(n, 1, 48, 8));
    check({tag, " c8"}, c8, ref_val(n, 2, 48, 8));
    check({tag, " a4"}, a4, ref_val(n, 0, 48, 4));
    check({tag, " b4"}, b4, ref_val(n, 1, 48, 4));
    check({tag, " c4"}, c4, ref_val(n, 2, 48, 4));
    check({tag, " af"}, af, ref_val(n, 0, 255, 8));
    check({tag, " bf"}, bf, ref_val(n, 1, 255, 8));
    check({tag, " cf"}, cf, ref_val(n, 2, 255, 8));
  endtask

  task automatic check_zero(string tag);
    check({tag, " a8"}, a8, 0);
    check({tag, " b8"}, b8, 0);
    check({tag, " c8"}, c8, 0);
    check({tag, " a4"}, a4, 0);
    check({tag, " af"}, af, 0);
    check({tag, " cf"}, cf, 0);
  endtask

  // Runs the four post-release edges against the fixed table.
  task automatic run_table(string tag);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s e%0d edges", tag, i + 1), n, tbl[i].edges);
      check($sformatf("%s e%0d a", tag, i + 1), a8, tbl[i].ea);
      check($sformatf("%s e%0d b", tag, i + 1), b8, tbl[i].eb);
      check($sformatf("%s e%0d c", tag, i + 1), c8, tbl[i].ec);
      check_all($sformatf("%s e%0d", tag, i + 1));
    end
  endtask

  // Release away from any rising edge.
  task automatic release_at_negedge();
    @(negedge clk);
    #($urandom_range(0, 3));
    rst = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1, 8'd0,  8'd0,  8'd0};
    tbl[1] = '{2, 8'd48, 8'd0,  8'd0};
    tbl[2] = '{3, 8'd48, 8'd48, 8'd0};
    tbl[3] = '{4, 8'd48, 8'd48, 8'd48};

    rst = 1'b0;
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    check_zero("reset held");
    @(negedge clk);
    rst = 1'b1;
    run_table("boot");

    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("hold%0d", i));
    end

    // Reset during WR_C: a,b loaded, c still zero.
    rst = 1'b0;
    #3;
    release_at_negedge();
    repeat (3) @(posedge clk);
    #2;
    check("wrc pre a", a8, 48);
    check("wrc pre b", b8, 48);
    check("wrc pre c", c8, 0);
    rst = 1'b0;
    #1;
    check_zero("wrc async");
    release_at_negedge();
    run_table("wrc restart");

    // Reset while in DONE.
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_zero("done async");
    release_at_negedge();
    run_table("done restart");

    // Random asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", i));
      if ($urandom_range(0, 9) == 0) begin
        #($urandom_range(0, 2));
        rst = 1'b0;
        #1;
        check_zero($sformatf("rnd%0d rst", i));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        release_at_negedge();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
